// File: rtl/fp_norm_ctrl_if.sv
// fp_norm_ctrl_if: input/output handshake bundle of the normalization controller
interface fp_norm_ctrl_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W:0]   in_mant;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [MANT_W-2:0] out_frac;
    logic [2:0]        out_flags;
    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_frac, out_flags
    );
    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_frac, out_flags
    );
endinterface

// File: rtl/fp_norm_ctrl.sv
// fp_norm_ctrl: multi-cycle leading-one normalization of an add/sub result
module fp_norm_ctrl #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int POS_W  = 5
) (
    input  logic         clk,
    input  logic         rst,
    fp_norm_ctrl_if.slave io
);
    typedef enum logic [1:0] {IDLE, EVAL, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {K_SPEC, K_ZERO, K_CARRY, K_NORM, K_LSH} kind_t;
    localparam logic [EXP_W-1:0] MAX_E = {EXP_W{1'b1}};

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic              sign_q;
    logic [EXP_W-1:0]  exp_q;
    logic [MANT_W:0]   mant_q;
    logic [POS_W-1:0]  shamt_q, shamt_d, lead;
    logic              out_sign_q;
    logic [EXP_W-1:0]  out_exp_q, out_exp_d;
    logic [MANT_W-2:0] out_frac_q, out_frac_d, shifted;
    logic [2:0]        out_flags_q;
    logic [EXP_W:0]    inc;
    logic [EXP_W-1:0]  dec;
    logic              ovf, unf, lsh_ok;

    always_comb
        state_d = (state_q == IDLE)  ? (io.in_valid ? EVAL : IDLE) :
                  (state_q == EVAL)  ? SHIFT :
                  (state_q == SHIFT) ? DONE :
                  (io.out_ready ? IDLE : DONE);

    // highest set bit wins because later iterations overwrite earlier ones
    always_comb begin
        lead = '0;
        for (int i = 0; i < MANT_W; i++)
            if (mant_q[i]) lead = POS_W'(i);
    end

    assign shamt_d = POS_W'(MANT_W - 1) - lead;
    assign kind_d  = (exp_q == MAX_E)  ? K_SPEC  :
                     (mant_q == '0)    ? K_ZERO  :
                     mant_q[MANT_W]    ? K_CARRY :
                     mant_q[MANT_W-1]  ? K_NORM  : K_LSH;

    assign inc     = {1'b0, exp_q} + (EXP_W+1)'(1);
    assign dec     = exp_q - EXP_W'(shamt_q);
    assign shifted = mant_q[MANT_W-2:0] << shamt_q;
    assign lsh_ok  = {1'b0, exp_q} > (EXP_W+1)'(shamt_q);
    assign ovf     = (kind_q == K_CARRY) && (inc >= {1'b0, MAX_E});
    assign unf     = (kind_q == K_LSH) && !lsh_ok;

    assign out_exp_d  = (kind_q == K_SPEC || ovf)   ? MAX_E :
                        (kind_q == K_CARRY)         ? inc[EXP_W-1:0] :
                        (kind_q == K_NORM)          ? exp_q :
                        (kind_q == K_LSH && lsh_ok) ? dec : '0;
    assign out_frac_d = (kind_q == K_SPEC || kind_q == K_NORM) ? mant_q[MANT_W-2:0] :
                        (kind_q == K_CARRY && !ovf)            ? mant_q[MANT_W-1:1] :
                        (kind_q == K_LSH && lsh_ok)            ? shifted : '0;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= IDLE;
            kind_q      <= K_SPEC;
            shamt_q     <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_frac_q  <= '0;
            out_flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && io.in_valid) begin
                sign_q <= io.in_sign;
                exp_q  <= io.in_exp;
                mant_q <= io.in_mant;
            end
            if (state_q == EVAL) begin
                kind_q  <= kind_d;
                shamt_q <= shamt_d;
            end
            if (state_q == SHIFT) begin
                out_sign_q  <= sign_q;
                out_exp_q   <= out_exp_d;
                out_frac_q  <= out_frac_d;
                out_flags_q <= {ovf, unf, kind_q == K_ZERO};
            end
        end

    // in_ready is gated by rst so it reads 0 for the whole reset pulse
    assign io.in_ready  = (state_q == IDLE) && !rst;
    assign io.out_valid = (state_q == DONE);
    assign io.out_sign  = out_sign_q;
    assign io.out_exp   = out_exp_q;
    assign io.out_frac  = out_frac_q;
    assign io.out_flags = out_flags_q;
endmodule

// File: tb/tb_fp_norm_ctrl.sv
// tb_fp_norm_ctrl: randomized scoreboard bench for the normalization controller
module tb_fp_norm_ctrl;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic [2:0]  flags;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   bp_mode = 0;
    res_t exp_q[$];
    time  t_q[$];

    fp_norm_ctrl_if #(.MANT_W(24), .EXP_W(8)) ifc ();
    fp_norm_ctrl #(.MANT_W(24), .EXP_W(8), .POS_W(5)) dut (.clk(clk), .rst(rst), .io(ifc));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic res_t model(input logic s, input logic [7:0] e, input logic [24:0] m);
        res_t r;
        int   mm = int'(m);
        int   ee = int'(e);
        int   sh = 0;
        r = '{sign: s, exp: 8'd0, frac: 23'd0, flags: 3'd0};
        if (ee == 255) begin
            r.exp  = 8'd255;
            r.frac = 23'(mm % (1 << 23));
        end else if (mm == 0) r.flags = 3'b001;
        else if (mm >= (1 << 24)) begin
            if (ee + 1 >= 255) begin
                r.exp   = 8'd255;
                r.flags = 3'b100;
            end else begin
                r.exp  = 8'(ee + 1);
                r.frac = 23'((mm / 2) % (1 << 23));
            end
        end else if (mm >= (1 << 23)) begin
            r.exp  = e;
            r.frac = 23'(mm % (1 << 23));
        end else begin
            while (mm < (1 << 23)) begin
                mm = mm * 2;
                sh++;
            end
            if (ee > sh) begin
                r.exp  = 8'(ee - sh);
                r.frac = 23'(mm % (1 << 23));
            end else r.flags = 3'b010;
        end
        return r;
    endfunction

    // called at a falling edge; returns one falling edge after the accept
    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m);
        int n = 0;
        while (ifc.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) chk("in_ready_timeout", 32'(ifc.in_ready), 32'd1);
        ifc.in_valid = 1'b1;
        ifc.in_sign  = s;
        ifc.in_exp   = e;
        ifc.in_mant  = m;
        exp_q.push_back(model(s, e, m));
        t_q.push_back($time);
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n == 300) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        ifc.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            ifc.out_ready = (bp_mode == 2) ? 1'b0 : (bp_mode == 1) ? 1'($urandom % 2) : 1'b1;
        end
    end

    initial begin
        logic seen = 1'b0;
        res_t snap, e;
        time  t0;
        forever begin
            @(negedge clk);
            if (ifc.out_valid !== 1'b1) seen = 1'b0;
            else if (!seen) begin
                seen = 1'b1;
                snap = {ifc.out_sign, ifc.out_exp, ifc.out_frac, ifc.out_flags};
                if (exp_q.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
                else begin
                    e  = exp_q.pop_front();
                    t0 = t_q.pop_front();
                    chk("out_sign", 32'(ifc.out_sign), 32'(e.sign));
                    chk("out_exp", 32'(ifc.out_exp), 32'(e.exp));
                    chk("out_frac", 32'(ifc.out_frac), 32'(e.frac));
                    chk("out_flags", 32'(ifc.out_flags), 32'(e.flags));
                    chk("latency", 32'(($time - t0) / 10), 32'd3);
                end
            end else begin
                chk("hold_stable", 32'({ifc.out_sign, ifc.out_exp, ifc.out_frac, ifc.out_flags}), 32'(snap));
                chk("hold_in_ready", 32'(ifc.in_ready), 32'd0);
            end
        end
    end

    initial begin
        int n;
        logic [24:0] m;
        logic [7:0]  e;
        int          pos;
        ifc.in_valid = 1'b0;
        ifc.in_sign  = 1'b0;
        ifc.in_exp   = '0;
        ifc.in_mant  = '0;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_outputs", 32'({ifc.out_sign, ifc.out_exp, ifc.out_frac, ifc.out_flags}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);

        send(1'b0, 8'h80, 25'h0800000);
        send(1'b0, 8'h7F, 25'h1800000);
        send(1'b1, 8'hFE, 25'h1000000);
        send(1'b0, 8'h80, 25'h0000001);
        send(1'b0, 8'h10, 25'h0000001);
        send(1'b1, 8'h55, 25'h0000000);
        send(1'b0, 8'hFF, 25'h0123456);
        send(1'b0, 8'h00, 25'h0C00001);
        drain();

        // downstream stall: the result must hold and new operands be ignored
        bp_mode = 2;
        send(1'b1, 8'h40, 25'h0003ABC);
        n = 0;
        while (ifc.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached_done", 32'(ifc.out_valid), 32'd1);
        repeat (5) begin
            ifc.in_valid = 1'b1;
            ifc.in_mant  = 25'($urandom);
            ifc.in_exp   = 8'($urandom);
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        bp_mode = 0;
        drain();

        bp_mode = 1;
        repeat (60) begin
            pos = $urandom_range(0, 25);
            m = (pos == 25) ? 25'd0 : 25'((1 << pos) | ($urandom & ((1 << pos) - 1)));
            case ($urandom_range(0, 5))
                0: e = 8'd0;
                1: e = 8'd254;
                2: e = 8'd255;
                3: e = 8'($urandom_range(1, 30));
                default: e = 8'($urandom);
            endcase
            send(1'($urandom), e, m);
        end
        bp_mode = 0;
        drain();

        send(1'b1, 8'h7F, 25'h1800000);
        drain();
        // abort in SHIFT: nothing must come out and the outputs clear
        send(1'b1, 8'h90, 25'h0012345);
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        t_q.delete();
        chk("abort_in_ready", 32'(ifc.in_ready), 32'd0);
        chk("abort_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("abort_outputs", 32'({ifc.out_sign, ifc.out_exp, ifc.out_frac, ifc.out_flags}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_release_in_ready", 32'(ifc.in_ready), 32'd1);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(ifc.out_valid), 32'd0);
        end

        send(1'b0, 8'h20, 25'h0000300);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
